// File: rtl/dht11_sampler.sv
// -----------------------------------------------------------------------------
// dht11_sampler
//   Schedules reads from a DHT11 controller. It starts a read periodically, or
//   at once on request. Each read has a timeout. After a failure it waits a
//   holdoff and retries, and it gives up after MAX_RETRY consecutive failures.
//   It keeps the last good humidity and temperature bytes, and optionally
//   their BCD forms.
//
//   Optional feature: define DHT11_SAMPLER_BCD_EN to get registered BCD outputs.
//   Without it, o_rh_bcd and o_t_bcd are tied to 0.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   i_enable       level, enables periodic sampling
//   i_force        pulse, request an immediate read (honoured only in IDLE)
//   i_done/i_valid done pulse and checksum-ok flag from the controller
//   i_rh, i_t      humidity / temperature integer bytes from the controller
//   o_start        one-cycle start pulse to the controller
//   o_ctrl_rst     one-cycle pulse resetting a hung controller (on timeout)
//   o_rh, o_t      last good humidity / temperature
//   o_rh_bcd/o_t_bcd BCD of o_rh / o_t (0 unless BCD enabled)
//   o_update       one-cycle pulse when a good reading is latched
//   o_fail         level, retries exhausted
//   o_err_cnt      saturating count of failed transactions
//   o_busy         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dht11_sampler #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int PERIOD_MS  = 2000,
   parameter int TIMEOUT_MS = 40,
   parameter int RETRY_MS   = 1000,
   parameter int MAX_RETRY  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_enable,
   input  logic       i_force,
   input  logic       i_done,
   input  logic       i_valid,
   input  logic [7:0] i_rh,
   input  logic [7:0] i_t,
   output logic       o_start,
   output logic       o_ctrl_rst,
   output logic [7:0] o_rh,
   output logic [7:0] o_t,
   output logic [7:0] o_rh_bcd,
   output logic [7:0] o_t_bcd,
   output logic       o_update,
   output logic       o_fail,
   output logic [7:0] o_err_cnt,
   output logic       o_busy
);

   localparam int DIV   = CLK_HZ / 1000;
   localparam int MS_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W = 16;

   localparam logic [MS_W-1:0]  MS_LAST      = MS_W'(DIV - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_MS - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_MS - 1);
   localparam logic [CNT_W-1:0] RETRY_LAST   = CNT_W'(RETRY_MS - 1);
   localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRY);

   typedef enum logic [1:0] {IDLE, TRIG, WAIT, HOLDOFF} state_t;

   state_t           state_q, state_d;
   logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [7:0]       retry_q, retry_d;
   logic             start_q, start_d;
   logic             ctrl_rst_q, ctrl_rst_d;
   logic [7:0]       rh_q, rh_d;
   logic [7:0]       t_q, t_d;
   logic             update_q, update_d;
   logic             fail_q, fail_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic tick;
   logic good;
   logic failure;

   // Free-running ms prescaler; the tick is the last count of each ms.
   assign tick     = (ms_cnt_q == MS_LAST);
   assign ms_cnt_d = tick ? '0 : ms_cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      to_cnt_d     = to_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      retry_d      = retry_q;
      start_d      = 1'b0;
      ctrl_rst_d   = 1'b0;
      rh_d         = rh_q;
      t_d          = t_q;
      update_d     = 1'b0;
      fail_d       = fail_q;
      err_cnt_d    = err_cnt_q;
      good         = 1'b0;
      failure      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!i_enable)
               period_cnt_d = '0;
            else if (tick)
               period_cnt_d = period_cnt_q + 1'b1;
            if (i_force || (i_enable && tick && period_cnt_q == PERIOD_LAST)) begin
               state_d      = TRIG;
               period_cnt_d = '0;
               start_d      = 1'b1;
            end
         end
         TRIG: begin
            to_cnt_d = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            if (tick)
               to_cnt_d = to_cnt_q + 1'b1;
            // A done pulse wins over a timeout landing in the same cycle.
            if (i_done) begin
               if (i_valid)
                  good = 1'b1;
               else
                  failure = 1'b1;
            end else if (tick && to_cnt_q == TIMEOUT_LAST) begin
               failure    = 1'b1;
               ctrl_rst_d = 1'b1;
            end
         end
         HOLDOFF: begin
            if (tick) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
               if (hold_cnt_q == RETRY_LAST) begin
                  hold_cnt_d = '0;
                  state_d    = TRIG;
                  start_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (good) begin
         rh_d         = i_rh;
         t_d          = i_t;
         update_d     = 1'b1;
         retry_d      = '0;
         fail_d       = 1'b0;
         state_d      = IDLE;
         period_cnt_d = '0;
      end

      if (failure) begin
         err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
         if (retry_q + 8'd1 == RETRY_MAX) begin
            fail_d       = 1'b1;
            retry_d      = '0;
            state_d      = IDLE;
            period_cnt_d = '0;
         end else begin
            retry_d    = retry_q + 8'd1;
            hold_cnt_d = '0;
            state_d    = HOLDOFF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ms_cnt_q     <= '0;
         period_cnt_q <= '0;
         to_cnt_q     <= '0;
         hold_cnt_q   <= '0;
         retry_q      <= '0;
         start_q      <= 1'b0;
         ctrl_rst_q   <= 1'b0;
         rh_q         <= '0;
         t_q          <= '0;
         update_q     <= 1'b0;
         fail_q       <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         ms_cnt_q     <= ms_cnt_d;
         period_cnt_q <= period_cnt_d;
         to_cnt_q     <= to_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         retry_q      <= retry_d;
         start_q      <= start_d;
         ctrl_rst_q   <= ctrl_rst_d;
         rh_q         <= rh_d;
         t_q          <= t_d;
         update_q     <= update_d;
         fail_q       <= fail_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

`ifdef DHT11_SAMPLER_BCD_EN
   // Two-digit BCD. Values above 99 clamp to 99.
   function automatic logic [7:0] to_bcd(input logic [7:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      if (v > 8'd99)
         return 8'h99;
      tens  = 4'(v / 8'd10);
      units = 4'(v % 8'd10);
      return {tens, units};
   endfunction

   logic [7:0] rh_bcd_q, rh_bcd_d;
   logic [7:0] t_bcd_q, t_bcd_d;

   always_comb begin
      rh_bcd_d = rh_bcd_q;
      t_bcd_d  = t_bcd_q;
      if (good) begin
         rh_bcd_d = to_bcd(i_rh);
         t_bcd_d  = to_bcd(i_t);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rh_bcd_q <= '0;
         t_bcd_q  <= '0;
      end else begin
         rh_bcd_q <= rh_bcd_d;
         t_bcd_q  <= t_bcd_d;
      end
   end

   assign o_rh_bcd = rh_bcd_q;
   assign o_t_bcd  = t_bcd_q;
`else
   assign o_rh_bcd = 8'h00;
   assign o_t_bcd  = 8'h00;
`endif

   assign o_start    = start_q;
   assign o_ctrl_rst = ctrl_rst_q;
   assign o_rh       = rh_q;
   assign o_t        = t_q;
   assign o_update   = update_q;
   assign o_fail     = fail_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dht11_sampler.sv
// -----------------------------------------------------------------------------
// tb_dht11_sampler
//   Directed bench for dht11_sampler with a 10-cycle ms tick.
//   Parameters: CLK_HZ=10_000, PERIOD_MS=5, TIMEOUT_MS=3, RETRY_MS=2,
//   MAX_RETRY=3.
//   cyc counts posedges. The pulse monitors sample 1 ns after each posedge.
//   Inputs are driven on negedges.
// -----------------------------------------------------------------------------
module tb_dht11_sampler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_enable = 1'b0;
   logic       i_force = 1'b0;
   logic       i_done = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_rh = 8'd0;
   logic [7:0] i_t = 8'd0;
   logic       o_start, o_ctrl_rst, o_update, o_fail, o_busy;
   logic [7:0] o_rh, o_t, o_rh_bcd, o_t_bcd, o_err_cnt;

   always #5 clk = ~clk;

   dht11_sampler #(
      .CLK_HZ(10_000), .PERIOD_MS(5), .TIMEOUT_MS(3), .RETRY_MS(2), .MAX_RETRY(3)
   ) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_force(i_force),
      .i_done(i_done), .i_valid(i_valid), .i_rh(i_rh), .i_t(i_t),
      .o_start(o_start), .o_ctrl_rst(o_ctrl_rst), .o_rh(o_rh), .o_t(o_t),
      .o_rh_bcd(o_rh_bcd), .o_t_bcd(o_t_bcd), .o_update(o_update),
      .o_fail(o_fail), .o_err_cnt(o_err_cnt), .o_busy(o_busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int start_cnt = 0, ctrl_cnt = 0, upd_cnt = 0;
   int last_start = 0, last_ctrl = 0;
   always @(posedge clk) begin
      #1;
      if (o_start) begin start_cnt++; last_start = cyc; end
      if (o_ctrl_rst) begin ctrl_cnt++; last_ctrl = cyc; end
      if (o_update) upd_cnt++;
   end

   int n_chk = 0, n_err = 0;
   int rel0, s, f, u0, c0, st0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; i_enable = 1'b0; i_force = 1'b0; i_done = 1'b0; i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rel0 = cyc;
   endtask

   task automatic check_zero();
      chk("rst_start", int'(o_start), 0);
      chk("rst_ctrl_rst", int'(o_ctrl_rst), 0);
      chk("rst_rh", int'(o_rh), 0);
      chk("rst_t", int'(o_t), 0);
      chk("rst_rh_bcd", int'(o_rh_bcd), 0);
      chk("rst_t_bcd", int'(o_t_bcd), 0);
      chk("rst_update", int'(o_update), 0);
      chk("rst_fail", int'(o_fail), 0);
      chk("rst_err_cnt", int'(o_err_cnt), 0);
      chk("rst_busy", int'(o_busy), 0);
   endtask

   // Waits a bounded number of cycles for a new o_start (or o_ctrl_rst) pulse.
   task automatic wait_evt(input string tag, input bit ctrl, input int budget);
      int base;
      int found;
      base  = ctrl ? ctrl_cnt : start_cnt;
      found = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((ctrl ? ctrl_cnt : start_cnt) != base) begin
            found = 1;
            break;
         end
      end
      chk(tag, found, 1);
   endtask

   // Presents i_done so that the posedge counted as cycle edge_k samples it.
   task automatic pulse_done_at(input int edge_k, input bit valid,
                                input logic [7:0] rh, input logic [7:0] t);
      while (cyc < edge_k - 1) @(negedge clk);
      i_done = 1'b1; i_valid = valid; i_rh = rh; i_t = t;
      @(negedge clk);
      i_done = 1'b0; i_valid = 1'b0;
   endtask

   initial begin
      // Periodic good read.
      do_reset();
      check_zero();
      i_enable = 1'b1;
      u0 = upd_cnt;
      wait_evt("a_start_seen", 1'b0, 60);
      chk("a_start_lat", last_start - rel0, 50);
      chk("a_busy", int'(o_busy), 1);
      s = last_start;
      pulse_done_at(s + 5, 1'b1, 8'd45, 8'd23);
      chk("a_rh", int'(o_rh), 45);
      chk("a_t", int'(o_t), 23);
`ifdef DHT11_SAMPLER_BCD_EN
      chk("a_rh_bcd", int'(o_rh_bcd), 'h45);
      chk("a_t_bcd", int'(o_t_bcd), 'h23);
`else
      chk("a_rh_bcd", int'(o_rh_bcd), 0);
      chk("a_t_bcd", int'(o_t_bcd), 0);
`endif
      repeat (3) @(negedge clk);
      chk("a_update_cnt", upd_cnt - u0, 1);
      chk("a_idle", int'(o_busy), 0);
      chk("a_err", int'(o_err_cnt), 0);

      // Three timeouts, then failure.
      do_reset();
      i_enable = 1'b1;
      c0 = ctrl_cnt; st0 = start_cnt;
      for (int k = 0; k < 3; k++) begin
         wait_evt("b_start_seen", 1'b0, 60);
         if (k == 0) chk("b_start_lat", last_start - rel0, 50);
         else        chk("b_retry_gap", last_start - last_ctrl, 20);
         wait_evt("b_ctrl_seen", 1'b1, 40);
         chk("b_timeout_lat", last_ctrl - last_start, 30);
      end
      chk("b_fail", int'(o_fail), 1);
      chk("b_err", int'(o_err_cnt), 3);
      chk("b_idle", int'(o_busy), 0);
      chk("b_starts", start_cnt - st0, 3);
      chk("b_ctrls", ctrl_cnt - c0, 3);

      // A good read clears o_fail and keeps the error count (t=105 saturates BCD).
      wait_evt("b2_start_seen", 1'b0, 60);
      chk("b2_period", last_start - last_ctrl, 50);
      s = last_start;
      pulse_done_at(s + 5, 1'b1, 8'd60, 8'd105);
      chk("b2_fail", int'(o_fail), 0);
      chk("b2_err", int'(o_err_cnt), 3);
      chk("b2_rh", int'(o_rh), 60);
      chk("b2_t", int'(o_t), 105);
`ifdef DHT11_SAMPLER_BCD_EN
      chk("b2_rh_bcd", int'(o_rh_bcd), 'h60);
      chk("b2_t_bcd", int'(o_t_bcd), 'h99);
`else
      chk("b2_t_bcd", int'(o_t_bcd), 0);
`endif

      // Checksum failure once, then a good retry.
      do_reset();
      i_enable = 1'b1;
      u0 = upd_cnt;
      wait_evt("c_start_seen", 1'b0, 60);
      s = last_start;
      pulse_done_at(s + 10, 1'b0, 8'd99, 8'd99);
      chk("c_err", int'(o_err_cnt), 1);
      chk("c_busy", int'(o_busy), 1);
      chk("c_rh_kept", int'(o_rh), 0);
      wait_evt("c_retry_seen", 1'b0, 30);
      chk("c_retry_gap", last_start - (s + 10), 20);
      s = last_start;
      pulse_done_at(s + 5, 1'b1, 8'd50, 8'd20);
      repeat (2) @(negedge clk);
      chk("c_update_cnt", upd_cnt - u0, 1);
      chk("c_fail", int'(o_fail), 0);
      chk("c_err_after", int'(o_err_cnt), 1);
      chk("c_rh", int'(o_rh), 50);

      // Done and timeout in the same cycle: done wins.
      do_reset();
      i_enable = 1'b1;
      wait_evt("d_start_seen", 1'b0, 60);
      s = last_start; u0 = upd_cnt; c0 = ctrl_cnt;
      pulse_done_at(s + 30, 1'b1, 8'd33, 8'd44);
      repeat (5) @(negedge clk);
      chk("d_no_ctrl_rst", ctrl_cnt - c0, 0);
      chk("d_update_cnt", upd_cnt - u0, 1);
      chk("d_err", int'(o_err_cnt), 0);
      chk("d_rh", int'(o_rh), 33);
      chk("d_idle", int'(o_busy), 0);

      // i_done in IDLE is ignored; forced reads; i_force in WAIT; rst in WAIT.
      do_reset();
      u0 = upd_cnt;
      pulse_done_at(cyc + 2, 1'b1, 8'd11, 8'd12);
      repeat (2) @(negedge clk);
      chk("e_idle_done_rh", int'(o_rh), 0);
      chk("e_idle_done_upd", upd_cnt - u0, 0);
      st0 = start_cnt;
      i_force = 1'b1; f = cyc + 1;
      @(negedge clk);
      i_force = 1'b0;
      chk("e_force_start", start_cnt - st0, 1);
      chk("e_force_lat", last_start, f);
      s = last_start;
      pulse_done_at(s + 2, 1'b1, 8'd77, 8'd78);
      chk("e_rh", int'(o_rh), 77);
      i_force = 1'b1; f = cyc + 1;
      @(negedge clk);
      i_force = 1'b0;
      chk("e_force2_lat", last_start, f);
      s = last_start; st0 = start_cnt; c0 = ctrl_cnt;
      while (cyc < s + 2) @(negedge clk);
      i_force = 1'b1;
      @(negedge clk);
      i_force = 1'b0;
      repeat (3) @(negedge clk);
      chk("e_force_in_wait", start_cnt - st0, 0);
      chk("e_busy_wait", int'(o_busy), 1);
      do_reset();
      check_zero();
      repeat (50) @(negedge clk);
      chk("e_no_start_after_rst", start_cnt - st0, 0);
      chk("e_no_ctrl_after_rst", ctrl_cnt - c0, 0);
      chk("e_idle_after_rst", int'(o_busy), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
